// File: rtl/pll_drp_pkg.sv
// Shared types and constants for the PLLE2_ADV DRP reconfiguration sequencer.
// Holds the sequencer state encoding, the DRP widths, the PLLE2 register map and the table entry record.
package pll_drp_pkg;

    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HOLD_RST,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_RELEASE,
        ST_WAIT_LOCK,
        ST_FAIL
    } state_t;

    // PLLE2_ADV DRP register map, for use by configuration tables
    localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT0_REG1  = 7'h08;
    localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT0_REG2  = 7'h09;
    localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT1_REG1  = 7'h0A;
    localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT1_REG2  = 7'h0B;
    localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT2_REG1  = 7'h0C;
    localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT2_REG2  = 7'h0D;
    localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT3_REG1  = 7'h0E;
    localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT3_REG2  = 7'h0F;
    localparam logic [DRP_ADDR_W-1:0] ADDR_CLKFBOUT_REG1 = 7'h14;
    localparam logic [DRP_ADDR_W-1:0] ADDR_CLKFBOUT_REG2 = 7'h15;
    localparam logic [DRP_ADDR_W-1:0] ADDR_DIVCLK        = 7'h16;
    localparam logic [DRP_ADDR_W-1:0] ADDR_LOCK1         = 7'h18;
    localparam logic [DRP_ADDR_W-1:0] ADDR_LOCK2         = 7'h19;
    localparam logic [DRP_ADDR_W-1:0] ADDR_LOCK3         = 7'h1A;
    localparam logic [DRP_ADDR_W-1:0] ADDR_POWER         = 7'h28;
    localparam logic [DRP_ADDR_W-1:0] ADDR_FILT1         = 7'h4E;
    localparam logic [DRP_ADDR_W-1:0] ADDR_FILT2         = 7'h4F;

    typedef struct packed {
        logic [DRP_ADDR_W-1:0] addr;
        logic [DRP_DATA_W-1:0] mask;
        logic [DRP_DATA_W-1:0] data;
    } drp_entry_t;

    // Keep the masked bits of the readback, then OR in the new field values
    function automatic logic [DRP_DATA_W-1:0] drp_rmw(
        input logic [DRP_DATA_W-1:0] rd_value,
        input logic [DRP_DATA_W-1:0] mask,
        input logic [DRP_DATA_W-1:0] data
    );
        return (rd_value & mask) | data;
    endfunction

endpackage

// File: rtl/pll_drp_reconfig_ctrl_timeout.sv
// Loadable saturating up-counter with an expiry flag (count >= limit).
// Shared by the reset-hold, DRDY and lock-wait phases of the sequencer.
module pll_drp_timeout #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg >= limit);

endmodule

// File: rtl/pll_drp_reconfig_ctrl.sv
// Run-time PLLE2_ADV reprogramming sequencer: holds the PLL in reset, walks an external
// read-modify-write DRP table for the selected configuration, releases reset and waits for lock.
module pll_drp_reconfig_ctrl
    import pll_drp_pkg::*;
#(
    parameter int CFG_W        = 2,
    parameter int NUM_ENTRIES  = 23,
    parameter int RST_HOLD     = 16,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65536,
    localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                  clk_in1,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CFG_W-1:0]      req_cfg,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CFG_W-1:0]      tbl_cfg,
    output logic [IDX_W-1:0]      tbl_idx,
    input  logic [DRP_ADDR_W-1:0] tbl_addr,
    input  logic [DRP_DATA_W-1:0] tbl_mask,
    input  logic [DRP_DATA_W-1:0] tbl_data,
    output logic                  pll_rst,
    input  logic                  pll_locked,
    output logic [DRP_ADDR_W-1:0] daddr,
    output logic [DRP_DATA_W-1:0] di,
    input  logic [DRP_DATA_W-1:0] do_in,
    output logic                  den,
    output logic                  dwe,
    input  logic                  drdy
);

    localparam int MAX_TIMEOUT = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int CNT_W       = $clog2(MAX_TIMEOUT + 1);

    state_t                state_reg, state_next;
    logic [CFG_W-1:0]      cfg_reg;
    logic [IDX_W-1:0]      idx_reg;
    drp_entry_t            entry_reg;
    logic [DRP_DATA_W-1:0] wdata_reg;
    logic                  error_reg;
    logic                  lock_meta_reg, lock_sync_reg;

    logic                  accept;
    logic                  last_entry;
    logic                  pll_rst_hold;
    logic                  cnt_load;
    logic                  cnt_expired;
    logic [CNT_W-1:0]      cnt_limit;

    assign last_entry = (idx_reg == IDX_W'(NUM_ENTRIES - 1));

    // The counter is loaded with 1 on entry, so each limit equals the cycles spent in the phase
    // including the request cycle that started it.
    pll_drp_timeout #(
        .CNT_W (CNT_W)
    ) u_timeout (
        .clk        (clk_in1),
        .rst        (reset),
        .load       (cnt_load),
        .load_value (CNT_W'(1)),
        .enable     (1'b1),
        .limit      (cnt_limit),
        .expired    (cnt_expired)
    );

    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cfg_reg       <= '0;
            idx_reg       <= '0;
            entry_reg     <= '0;
            wdata_reg     <= '0;
            error_reg     <= 1'b0;
            lock_meta_reg <= 1'b0;
            lock_sync_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            lock_meta_reg <= pll_locked;
            lock_sync_reg <= lock_meta_reg;
            if (accept) begin
                cfg_reg   <= req_cfg;
                idx_reg   <= '0;
                error_reg <= 1'b0;
            end
            if (state_reg == ST_RD_REQ) begin
                entry_reg.addr <= tbl_addr;
                entry_reg.mask <= tbl_mask;
                entry_reg.data <= tbl_data;
            end
            if ((state_reg == ST_RD_WAIT) && drdy) begin
                wdata_reg <= drp_rmw(do_in, entry_reg.mask, entry_reg.data);
            end
            if ((state_reg == ST_WR_WAIT) && drdy && !last_entry) begin
                idx_reg <= idx_reg + 1'b1;
            end
            if (state_next == ST_FAIL) begin
                error_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        accept       = 1'b0;
        cnt_load     = 1'b0;
        cnt_limit    = CNT_W'(DRDY_TIMEOUT - 1);
        req_ready    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        den          = 1'b0;
        dwe          = 1'b0;
        pll_rst_hold = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                busy      = 1'b0;
                req_ready = !reset;
                if (req_valid) begin
                    accept     = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = ST_HOLD_RST;
                end
            end
            ST_HOLD_RST: begin
                pll_rst_hold = 1'b1;
                cnt_limit    = CNT_W'(RST_HOLD);
                if (cnt_expired) state_next = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                pll_rst_hold = 1'b1;
                den          = 1'b1;
                cnt_load     = 1'b1;
                state_next   = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                pll_rst_hold = 1'b1;
                if (drdy)             state_next = ST_WR_REQ;
                else if (cnt_expired) state_next = ST_FAIL;
            end
            ST_WR_REQ: begin
                pll_rst_hold = 1'b1;
                den          = 1'b1;
                dwe          = 1'b1;
                cnt_load     = 1'b1;
                state_next   = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                pll_rst_hold = 1'b1;
                if (drdy)             state_next = last_entry ? ST_RELEASE : ST_RD_REQ;
                else if (cnt_expired) state_next = ST_FAIL;
            end
            ST_RELEASE: begin
                cnt_load   = 1'b1;
                state_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                cnt_limit = CNT_W'(LOCK_TIMEOUT - 1);
                if (lock_sync_reg) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end else if (cnt_expired) begin
                    state_next = ST_FAIL;
                end
            end
            ST_FAIL: begin
                busy       = 1'b0;
                state_next = ST_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Reset drives the PLL reset directly so it is asserted even before the clock runs
    assign pll_rst = reset | pll_rst_hold;
    assign daddr   = (state_reg == ST_RD_REQ) ? tbl_addr : entry_reg.addr;
    assign di      = wdata_reg;
    assign error   = error_reg;
    assign tbl_cfg = cfg_reg;
    assign tbl_idx = idx_reg;

endmodule

// File: tb/tb_pll_drp_reconfig_ctrl.sv
// Directed self-checking bench for pll_drp_reconfig_ctrl with a DRP slave, PLL lock model
// and a combinational configuration table.
module tb_pll_drp_reconfig_ctrl;

    logic        clk_in1 = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_cfg = 2'd0;
    logic        req_ready, busy, done, error;
    logic [1:0]  tbl_cfg;
    logic [4:0]  tbl_idx;
    logic [6:0]  tbl_addr;
    logic [15:0] tbl_mask, tbl_data;
    logic        pll_rst;
    logic        pll_locked = 1'b0;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic [15:0] do_in;
    logic        den, dwe;
    logic        drdy = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  cur_cfg = 2'd0;
    logic        drop_en = 1'b0;
    logic        hold_low = 1'b0;
    int          wr_count = 0;
    int          rd_count = 0;

    always #5 clk_in1 = ~clk_in1;

    pll_drp_reconfig_ctrl dut (
        .clk_in1    (clk_in1),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cfg    (req_cfg),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .tbl_cfg    (tbl_cfg),
        .tbl_idx    (tbl_idx),
        .tbl_addr   (tbl_addr),
        .tbl_mask   (tbl_mask),
        .tbl_data   (tbl_data),
        .pll_rst    (pll_rst),
        .pll_locked (pll_locked),
        .daddr      (daddr),
        .di         (di),
        .do_in      (do_in),
        .den        (den),
        .dwe        (dwe),
        .drdy       (drdy)
    );

    // Table: address encodes cfg/entry; keep the top nibble, write cfg-dependent low bits
    assign tbl_addr = {tbl_cfg, tbl_idx};
    assign tbl_mask = 16'hF000;
    assign tbl_data = {4'h0, tbl_cfg, 10'h123};
    assign do_in    = 16'hA5A5;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // PLL lock model: locks 5 cycles after reset release unless held low
    int lock_cnt = 0;
    always @(negedge clk_in1) begin
        if (pll_rst) begin
            pll_locked <= 1'b0;
            lock_cnt   <= 0;
        end else if (!hold_low) begin
            if (lock_cnt < 5) lock_cnt <= lock_cnt + 1;
            else              pll_locked <= 1'b1;
        end
    end

    // DRP slave (drdy 3 cycles after den) plus protocol and data checks
    int   dly = 0;
    logic pending = 1'b0;
    logic den_prev = 1'b0;
    logic busy_prev = 1'b0;
    always @(negedge clk_in1) begin
        if (reset) begin
            dly = 0; drdy = 1'b0; pending = 1'b0; den_prev = 1'b0;
            busy_prev = 1'b0; wr_count = 0; rd_count = 0;
        end else begin
            drdy = 1'b0;
            if (busy && !busy_prev) begin
                wr_count = 0;
                rd_count = 0;
            end
            if (dly == 1) begin
                drdy = 1'b1;
                pending = 1'b0;
            end
            if (dly > 0) dly--;
            if (dwe) check("dwe_only_with_den", den, 1);
            if (den) begin
                check("den_one_cycle", den_prev, 0);
                check("den_outstanding", pending, 0);
                if (dwe) begin
                    check("wr_addr", daddr, {cur_cfg, 5'(wr_count)});
                    check("wr_data", di, 16'hA000 | {4'h0, cur_cfg, 10'h123});
                    wr_count++;
                end else begin
                    check("rd_addr", daddr, {cur_cfg, 5'(rd_count)});
                    rd_count++;
                end
                if (!(drop_en && !dwe && tbl_idx == 5'd5)) begin
                    dly = 3;
                    pending = 1'b1;
                end
            end
            den_prev  = den;
            busy_prev = busy;
        end
    end

    task automatic wait_end(input int budget, output logic got_done, output int cycles);
        got_done = 1'b0;
        cycles = 0;
        while (cycles < budget) begin
            @(negedge clk_in1);
            cycles++;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (error) break;
        end
    endtask

    task automatic request(input logic [1:0] cfg);
        cur_cfg   = cfg;
        req_cfg   = cfg;
        req_valid = 1'b1;
        @(negedge clk_in1);
        req_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        int   cyc, hold, k, bad_ready;
        logic found, saw_done;

        // Reset values
        repeat (3) @(negedge clk_in1);
        check("rst_req_ready", req_ready, 0);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_den", den, 0);
        check("rst_dwe", dwe, 0);
        check("rst_daddr", daddr, 0);
        check("rst_di", di, 0);
        check("rst_tbl_idx", tbl_idx, 0);
        check("rst_tbl_cfg", tbl_cfg, 0);
        reset = 1'b0;
        @(negedge clk_in1);
        check("idle_req_ready", req_ready, 1);
        check("idle_pll_rst", pll_rst, 0);

        // Single full reconfiguration
        request(2'd0);
        check("acc_busy", busy, 1);
        check("acc_req_ready", req_ready, 0);
        check("acc_pll_rst", pll_rst, 1);
        hold = 0;
        while (!den && hold < 100) begin
            if (pll_rst) hold++;
            @(negedge clk_in1);
        end
        check("hold_ge_16", (hold >= 16), 1);
        wait_end(2000, got, cyc);
        check("cfg0_done", got, 1);
        check("cfg0_error", error, 0);
        check("cfg0_writes", wr_count, 23);
        $display("req cfg=0 done=%0d writes=%0d cycles=%0d", got, wr_count, cyc);
        @(negedge clk_in1);
        check("done_pulse_width", done, 0);
        check("post_done_busy", busy, 0);

        // Back-to-back requests with req_valid held
        cur_cfg = 2'd1; req_cfg = 2'd1; req_valid = 1'b1;
        @(negedge clk_in1);
        check("b2b_cfg1", tbl_cfg, 1);
        req_cfg = 2'd2;
        bad_ready = 0; got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (req_ready) bad_ready++;
            @(negedge clk_in1);
        end
        check("b2b_first_done", got, 1);
        check("b2b_ready_while_busy", bad_ready, 0);
        check("b2b_first_writes", wr_count, 23);
        $display("req cfg=1 done=%0d writes=%0d", got, wr_count);
        cur_cfg = 2'd2;
        @(negedge clk_in1);
        check("b2b_ready_after_done", req_ready, 1);
        @(negedge clk_in1);
        req_valid = 1'b0;
        check("b2b_second_busy", busy, 1);
        check("b2b_second_cfg", tbl_cfg, 2);
        wait_end(2000, got, cyc);
        check("b2b_second_done", got, 1);
        check("b2b_second_writes", wr_count, 23);
        $display("req cfg=2 done=%0d writes=%0d cycles=%0d", got, wr_count, cyc);

        // DRDY timeout on entry 5
        @(negedge clk_in1);
        drop_en = 1'b1;
        request(2'd3);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (den && !dwe && tbl_idx == 5'd5) begin
                found = 1'b1;
                break;
            end
            @(negedge clk_in1);
        end
        check("drdy_to_found_entry5", found, 1);
        k = 0; saw_done = 1'b0;
        while (!error && k < 200) begin
            @(negedge clk_in1);
            k++;
            if (done) saw_done = 1'b1;
        end
        check("drdy_to_cycles", k, 64);
        check("drdy_to_busy", busy, 0);
        check("drdy_to_no_done", saw_done, 0);
        check("drdy_to_pll_rst", pll_rst, 0);
        $display("req cfg=3 drdy timeout after %0d cycles error=%0d", k, error);
        @(negedge clk_in1);
        check("error_sticky", error, 1);
        check("fail_to_idle_ready", req_ready, 1);
        drop_en = 1'b0;
        request(2'd0);
        check("error_cleared", error, 0);
        wait_end(2000, got, cyc);
        check("recover_done", got, 1);
        $display("req cfg=0 done=%0d writes=%0d cycles=%0d", got, wr_count, cyc);

        // Lock timeout
        @(negedge clk_in1);
        hold_low = 1'b1;
        request(2'd1);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (busy && !pll_rst) begin
                found = 1'b1;
                break;
            end
            @(negedge clk_in1);
        end
        check("lock_to_release_found", found, 1);
        k = 0; saw_done = 1'b0;
        while (!error && k < 70000) begin
            @(negedge clk_in1);
            k++;
            if (done) saw_done = 1'b1;
        end
        check("lock_to_cycles", k, 65536);
        check("lock_to_pll_rst", pll_rst, 0);
        check("lock_to_busy", busy, 0);
        check("lock_to_no_done", saw_done, 0);
        $display("req cfg=1 lock timeout after %0d cycles error=%0d", k, error);
        hold_low = 1'b0;
        repeat (2) @(negedge clk_in1);

        // Reset during WR_WAIT, then restart from entry 0
        request(2'd2);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (den && dwe && tbl_idx == 5'd3) begin
                found = 1'b1;
                break;
            end
            @(negedge clk_in1);
        end
        check("mid_rst_found_write3", found, 1);
        @(negedge clk_in1);
        reset = 1'b1;
        #1;
        check("mid_rst_pll_rst", pll_rst, 1);
        check("mid_rst_den", den, 0);
        check("mid_rst_dwe", dwe, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_req_ready", req_ready, 0);
        check("mid_rst_tbl_idx", tbl_idx, 0);
        @(negedge clk_in1);
        reset = 1'b0;
        @(negedge clk_in1);
        check("post_rst_ready", req_ready, 1);
        request(2'd2);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (den) begin
                found = 1'b1;
                break;
            end
            @(negedge clk_in1);
        end
        check("restart_den_found", found, 1);
        check("restart_idx", tbl_idx, 0);
        check("restart_daddr", daddr, 7'h40);
        wait_end(2000, got, cyc);
        check("restart_done", got, 1);
        check("restart_writes", wr_count, 23);
        $display("req cfg=2 after reset done=%0d writes=%0d cycles=%0d", got, wr_count, cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
